// File: rtl/conv1d_pkg.sv
// rtl/conv1d_pkg.sv - shared opcodes, constants and stage type for the conv1d requant/pack block
package conv1d_pkg;

    localparam int INT32_SIZE = 32;
    localparam int PIPE_DEPTH = 4;

    localparam logic [6:0] CMD_REQ_BIAS    = 7'd60;
    localparam logic [6:0] CMD_REQ_MULT    = 7'd61;
    localparam logic [6:0] CMD_REQ_SHIFT   = 7'd62;
    localparam logic [6:0] CMD_REQ_OFFSET  = 7'd63;
    localparam logic [6:0] CMD_REQ_ACT_MIN = 7'd64;
    localparam logic [6:0] CMD_REQ_ACT_MAX = 7'd65;
    localparam logic [6:0] CMD_REQ_ISSUE   = 7'd70;
    localparam logic [6:0] CMD_REQ_READ    = 7'd71;
    localparam logic [6:0] CMD_REQ_STATUS  = 7'd72;
    localparam logic [6:0] CMD_REQ_FLUSH   = 7'd73;

    localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
    localparam logic signed [31:0] INT32_MAX = 32'sh7fff_ffff;

    // data holds x (S1), the 64-bit product p (S2) or h (S3)
    typedef struct packed {
        logic        valid;
        logic        sat;
        logic [5:0]  shift;
        logic [63:0] data;
    } req_stage_t;

endpackage

// File: rtl/requant_core.sv
// rtl/requant_core.sv - four-stage bias/multiply/round/clamp requantization pipeline
module requant_core
    import conv1d_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [31:0]           acc,
    input  logic [31:0]           bias,
    input  logic [31:0]           mult,
    input  logic [5:0]            shift,
    input  logic [31:0]           out_offset,
    input  logic [31:0]           act_min,
    input  logic [31:0]           act_max,
    output logic [PIPE_DEPTH-1:0] stage_valid,
    output logic                  out_valid,
    output logic [7:0]            out_data
);

    req_stage_t s1, s2, s3;
    logic [31:0] s1_mult;
    logic        s4_valid;
    logic [7:0]  s4_data;

    logic [31:0]        x_sum, x_in;
    logic signed [63:0] xa, ma, prod, nudge, rsum, quo;
    logic               sat2;
    logic signed [31:0] h, hs, hsh, r, y;
    logic [5:0]         e;
    logic [32:0]        mask, rem, thr;
    logic [7:0]         y8;

    always_comb begin
        x_sum = acc + bias;
        x_in  = (!shift[5] && shift != 6'd0) ? (x_sum << shift[4:0]) : x_sum;
    end

    always_comb begin
        xa   = {{32{s1.data[31]}}, s1.data[31:0]};
        ma   = {{32{s1_mult[31]}}, s1_mult};
        prod = xa * ma;
        sat2 = (s1.data[31:0] == INT32_MIN) && (s1_mult == INT32_MIN);
    end

    // floor shift then correct negatives so the divide by 2^31 truncates toward zero
    always_comb begin
        nudge = s2.data[63] ? -64'sd1073741823 : 64'sd1073741824;
        rsum  = $signed(s2.data) + nudge;
        quo   = rsum >>> 31;
        if (rsum[63] && rsum[30:0] != 31'd0) begin
            quo = quo + 64'sd1;
        end
        h = s2.sat ? INT32_MAX : quo[31:0];
    end

    always_comb begin
        hs   = s3.data[31:0];
        e    = 6'd0 - s3.shift;
        mask = (33'd1 << e) - 33'd1;
        rem  = {1'b0, hs} & mask;
        thr  = (mask >> 1) + {32'd0, hs[31]};
        hsh  = hs >>> e;
        r    = s3.shift[5] ? hsh + {31'd0, rem > thr} : hs;
        y    = r + out_offset;
        if (y < $signed(act_min)) begin
            y8 = act_min[7:0];
        end else if (y > $signed(act_max)) begin
            y8 = act_max[7:0];
        end else begin
            y8 = y[7:0];
        end
    end

    always_ff @(posedge clk) begin
        s1       <= '{valid: in_valid, sat: 1'b0, shift: shift, data: {32'd0, x_in}};
        s1_mult  <= mult;
        s2       <= '{valid: s1.valid, sat: sat2, shift: s1.shift, data: prod};
        s3       <= '{valid: s2.valid, sat: 1'b0, shift: s2.shift, data: {32'd0, h}};
        s4_valid <= s3.valid;
        s4_data  <= y8;
        if (reset) begin
            s1.valid <= 1'b0;
            s2.valid <= 1'b0;
            s3.valid <= 1'b0;
            s4_valid <= 1'b0;
        end
    end

    assign stage_valid = {s4_valid, s3.valid, s2.valid, s1.valid};
    assign out_valid   = s4_valid;
    assign out_data    = s4_data;

    logic unused_bits;
    assign unused_bits = ^{s1.sat, s1.data[63:32], s3.sat, s3.data[63:32], quo[63:32]};

endmodule

// File: rtl/conv1d_requant_pack.sv
// rtl/conv1d_requant_pack.sv - per-channel requant tables, command decode and int8 word packing
module conv1d_requant_pack
    import conv1d_pkg::*;
#(
    parameter int MAX_CHANNELS = 128
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            cmd,
    input  logic [INT32_SIZE-1:0] inp0,
    input  logic [INT32_SIZE-1:0] inp1,
    output logic [INT32_SIZE-1:0] ret,
    output logic                  word_ready
);

    localparam int CH_W = $clog2(MAX_CHANNELS);

    logic [31:0] bias_tbl  [MAX_CHANNELS];
    logic [31:0] mult_tbl  [MAX_CHANNELS];
    logic [5:0]  shift_tbl [MAX_CHANNELS];

    logic [CH_W-1:0]       ch;
    logic [31:0]           out_offset, act_min, act_max, out_word;
    logic [23:0]           partial;
    logic [1:0]            lane;
    logic                  overflow;
    logic [PIPE_DEPTH-1:0] stage_valid;
    logic                  res_valid, land;
    logic [7:0]            res_data;
    logic [2:0]            pending_cnt;

    assign ch = inp0[CH_W-1:0];

    always_ff @(posedge clk) begin
        case (cmd)
            CMD_REQ_BIAS:  bias_tbl[ch]  <= inp1;
            CMD_REQ_MULT:  mult_tbl[ch]  <= inp1;
            CMD_REQ_SHIFT: shift_tbl[ch] <= inp1[5:0];
            default: ;
        endcase
    end

    requant_core u_core (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (cmd == CMD_REQ_ISSUE),
        .acc         (inp1),
        .bias        (bias_tbl[ch]),
        .mult        (mult_tbl[ch]),
        .shift       (shift_tbl[ch]),
        .out_offset  (out_offset),
        .act_min     (act_min),
        .act_max     (act_max),
        .stage_valid (stage_valid),
        .out_valid   (res_valid),
        .out_data    (res_data)
    );

    always_comb begin
        pending_cnt = 3'd0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            pending_cnt = pending_cnt + {2'd0, stage_valid[i]};
        end
    end

    // a flush on the landing edge drops that result
    assign land = res_valid && (cmd != CMD_REQ_FLUSH);

    always_ff @(posedge clk) begin
        if (reset) begin
            ret        <= '0;
            word_ready <= 1'b0;
            overflow   <= 1'b0;
            lane       <= 2'd0;
            partial    <= 24'd0;
            out_word   <= 32'd0;
            out_offset <= 32'd0;
            act_min    <= 32'hffff_ff80;
            act_max    <= 32'd127;
        end else begin
            case (cmd)
                CMD_REQ_OFFSET:  out_offset <= inp1;
                CMD_REQ_ACT_MIN: act_min    <= inp1;
                CMD_REQ_ACT_MAX: act_max    <= inp1;
                CMD_REQ_READ: begin
                    ret        <= out_word;
                    word_ready <= 1'b0;
                end
                CMD_REQ_STATUS: ret <= {overflow, {(INT32_SIZE-6){1'b0}}, pending_cnt, lane};
                CMD_REQ_FLUSH: begin
                    lane     <= 2'd0;
                    partial  <= 24'd0;
                    overflow <= 1'b0;
                end
                default: ;
            endcase
            if (land) begin
                case (lane)
                    2'd0: partial[7:0]   <= res_data;
                    2'd1: partial[15:8]  <= res_data;
                    2'd2: partial[23:16] <= res_data;
                    default: begin
                        out_word   <= {res_data, partial};
                        word_ready <= 1'b1;
                        partial    <= 24'd0;
                        if (word_ready) begin
                            overflow <= 1'b1;
                        end
                    end
                endcase
                lane <= lane + 2'd1;
            end
        end
    end

    logic unused_inp0;
    assign unused_inp0 = ^inp0[INT32_SIZE-1:CH_W];

endmodule

// File: tb/tb_conv1d_requant_pack.sv
// tb/tb_conv1d_requant_pack.sv - scoreboard bench for conv1d_requant_pack against an arithmetic model
module tb_conv1d_requant_pack;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  cmd   = 7'd0;
    logic [31:0] inp0  = 32'd0;
    logic [31:0] inp1  = 32'd0;
    logic [31:0] ret;
    logic        word_ready;

    conv1d_requant_pack dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd),
        .inp0       (inp0),
        .inp1       (inp1),
        .ret        (ret),
        .word_ready (word_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    longint      m_bias [128];
    longint      m_mult [128];
    int          m_shift[128];
    longint      m_off, m_min, m_max;
    int          m_lane;
    logic [31:0] m_partial, m_word;
    bit          m_ready, m_ovf;
    int          land_cyc[$];
    logic [7:0]  land_val[$];

    int          q_cyc[$];
    bit          q_kind[$];
    logic [31:0] q_val[$];
    string       q_name[$];
    logic [31:0] mon_act;

    task automatic push_exp(bit kind, logic [31:0] val, string name);
        q_cyc.push_back(cyc);
        q_kind.push_back(kind);
        q_val.push_back(val);
        q_name.push_back(name);
    endtask

    function automatic longint wrap32(longint v);
        int t;
        t = int'(v);
        return longint'(t);
    endfunction

    // reference: integer arithmetic, divide truncating toward zero, round-half-away for the right shift
    function automatic logic [7:0] ref_requant(longint acc, int ch);
        longint x, p, h, r, y, den, mag, q, rm;
        int sh;
        sh = m_shift[ch];
        x  = wrap32(acc + m_bias[ch]);
        if (sh > 0) x = wrap32(x * (longint'(1) << sh));
        p = x * m_mult[ch];
        if (x == -64'sd2147483648 && m_mult[ch] == -64'sd2147483648) h = 2147483647;
        else if (p >= 0) h = (p + (longint'(1) << 30)) / (longint'(1) << 31);
        else h = (p + 1 - (longint'(1) << 30)) / (longint'(1) << 31);
        if (sh < 0) begin
            den = longint'(1) << (-sh);
            mag = (h < 0) ? -h : h;
            q   = mag / den;
            rm  = mag % den;
            if (2 * rm >= den) q = q + 1;
            r = (h < 0) ? -q : q;
        end else begin
            r = h;
        end
        y = wrap32(r + m_off);
        if (y < m_min) y = m_min;
        else if (y > m_max) y = m_max;
        return 8'(y);
    endfunction

    task automatic model_reset();
        m_off = 0; m_min = -128; m_max = 127;
        m_lane = 0; m_partial = 0; m_word = 0; m_ready = 0; m_ovf = 0;
        land_cyc.delete();
        land_val.delete();
    endtask

    task automatic model_edge(logic [6:0] c, logic [31:0] a, logic [31:0] b);
        int pend;
        bit landing, wr_old;
        logic [7:0] lv;
        pend = 0;
        foreach (land_cyc[i]) if (land_cyc[i] >= cyc && land_cyc[i] <= cyc + 3) pend++;
        landing = (land_cyc.size() > 0) && (land_cyc[0] == cyc);
        lv = 8'd0;
        if (landing) begin
            lv = land_val.pop_front();
            void'(land_cyc.pop_front());
        end
        wr_old = m_ready;
        if (c == 7'd71) begin
            push_exp(0, m_word, "read_word");
            m_ready = 0;
        end
        if (c == 7'd72) push_exp(0, {m_ovf, 26'd0, 3'(pend), 2'(m_lane)}, "status");
        if (c == 7'd73) begin
            m_lane = 0; m_partial = 0; m_ovf = 0;
        end else if (landing) begin
            m_partial[m_lane*8 +: 8] = lv;
            if (m_lane == 3) begin
                if (wr_old) m_ovf = 1;
                m_word = m_partial; m_ready = 1; m_partial = 0; m_lane = 0;
            end else begin
                m_lane++;
            end
        end
        case (c)
            7'd60: m_bias[a[6:0]]  = longint'($signed(b));
            7'd61: m_mult[a[6:0]]  = longint'($signed(b));
            7'd62: m_shift[a[6:0]] = int'($signed(b[5:0]));
            7'd63: m_off = longint'($signed(b));
            7'd64: m_min = longint'($signed(b));
            7'd65: m_max = longint'($signed(b));
            7'd70: begin
                land_cyc.push_back(cyc + 4);
                land_val.push_back(ref_requant(longint'($signed(b)), int'(a[6:0])));
            end
            default: ;
        endcase
        push_exp(1, {31'd0, m_ready}, "word_ready");
    endtask

    task automatic step(logic [6:0] c, logic [31:0] a, logic [31:0] b);
        cmd = c; inp0 = a; inp1 = b;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(c, a, b);
        cmd = 7'd0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(7'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1; cmd = 7'd0;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        model_reset();
        push_exp(0, 32'd0, "reset_ret");
        push_exp(1, 32'd0, "reset_ready");
    endtask

    task automatic cfg(logic [31:0] ch, logic [31:0] b, logic [31:0] m, logic [31:0] s);
        step(7'd60, ch, b);
        step(7'd61, ch, m);
        step(7'd62, ch, s);
    endtask

    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            mon_act = q_kind[0] ? {31'd0, word_ready} : ret;
            checks++;
            if (mon_act !== q_val[0]) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%h expected=%h", q_name[0], q_cyc[0], mon_act, q_val[0]);
            end
            void'(q_cyc.pop_front());
            void'(q_kind.pop_front());
            void'(q_val.pop_front());
            void'(q_name.pop_front());
        end
    end

    initial begin
        int sel;
        logic [31:0] acc_r;
        model_reset();
        repeat (3) do_reset();
        step(7'd72, 0, 0);
        step(7'd71, 0, 0);

        // basic path: 25 in every lane
        cfg(0, 20, 32'h4000_0000, -1);
        step(7'd63, 0, -5);
        repeat (4) step(7'd70, 0, 100);
        idle(4);
        step(7'd71, 0, 0);

        // rounding
        step(7'd63, 0, 0);
        cfg(1, 0, 32'h4000_0000, 0);
        cfg(2, 0, 32'h4000_0000, -1);
        step(7'd70, 1, -3);
        step(7'd70, 2, -3);
        step(7'd70, 2, -6);
        step(7'd70, 2, 6);
        idle(4);
        step(7'd71, 0, 0);

        // clamp and saturation
        cfg(3, 0, 32'h7fff_ffff, 4);
        cfg(4, 0, 32'h8000_0000, 0);
        step(7'd70, 3, 1000);
        step(7'd70, 3, -1000);
        idle(4);
        step(7'd64, 0, 0);
        step(7'd70, 3, -1000);
        step(7'd70, 4, 32'h8000_0000);
        idle(4);
        step(7'd71, 0, 0);
        step(7'd64, 0, -128);

        // per-channel tables and pending count
        cfg(5, 7, 32'h2000_0000, 0);
        cfg(6, -300, 32'h6000_0000, -3);
        cfg(7, 55, 32'h1234_5678, 2);
        cfg(8, -9, 32'h7000_0000, -5);
        for (int k = 1; k <= 4; k++) begin
            for (int j = 0; j < k; j++) step(7'd70, 5 + j, 400 * (j + 1) - 900);
            step(7'd72, 0, 0);
            idle(5);
        end
        step(7'd72, 0, 0);
        step(7'd73, 0, 0);
        for (int j = 0; j < 4; j++) step(7'd70, 5 + j, 1500 - 700 * j);
        idle(4);
        step(7'd71, 0, 0);

        // overflow, read on completion edge, flush
        step(7'd73, 0, 0);
        for (int j = 0; j < 8; j++) step(7'd70, 5 + (j % 4), 100 * j - 350);
        idle(5);
        step(7'd72, 0, 0);
        step(7'd71, 0, 0);
        for (int j = 0; j < 4; j++) step(7'd70, 0, 100 + j);
        idle(4);
        for (int j = 0; j < 4; j++) step(7'd70, 3, 10 * j);
        idle(3);
        step(7'd71, 0, 0);
        step(7'd72, 0, 0);
        step(7'd71, 0, 0);
        step(7'd73, 0, 0);
        step(7'd72, 0, 0);

        // reset mid-operation
        step(7'd70, 0, 100);
        step(7'd70, 0, 100);
        do_reset();
        step(7'd72, 0, 0);
        idle(5);
        step(7'd72, 0, 0);
        step(7'd70, 3, -1000);
        step(7'd70, 3, 1000);
        step(7'd70, 0, 100);
        step(7'd70, 32'h0000_0181, -3);
        idle(4);
        step(7'd71, 0, 0);

        // randomized traffic on wrapped channel indices
        for (int c = 10; c < 16; c++)
            cfg(c, int'($urandom_range(0, 4000)) - 2000, $urandom, int'($urandom_range(0, 40)) - 20);
        step(7'd63, 0, int'($urandom_range(0, 40)) - 20);
        for (int i = 0; i < 120; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6) begin
                acc_r = (sel < 3) ? $urandom : 32'(int'($urandom_range(0, 200000)) - 100000);
                step(7'd70, ($urandom & 32'hffff_ff80) | 32'(10 + $urandom_range(0, 5)), acc_r);
            end else if (sel < 8) begin
                step(m_ready ? 7'd71 : 7'd0, 0, 0);
            end else if (sel == 8) begin
                step(7'd72, 0, 0);
            end else begin
                step(7'd0, 0, 0);
            end
        end
        idle(6);
        step(7'd72, 0, 0);
        step(7'd71, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (q_cyc.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", q_cyc.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv1d_requant_pack.md
Name: conv1d_requant_pack

Overview:
- Downstream stage of the conv1d accumulator CFU.
- Takes raw int32 conv1d accumulator values with a channel index, then adds the per-channel bias.
- Requantizes TFLite-style: per-channel quantized multiplier and shift, output offset, activation clamp.
- Packs four int8 results into one 32-bit word for the CPU to read. It uses the same cmd/inp0/inp1/ret command interface as conv1d.

Parameters:
- MAX_CHANNELS, 128, depth of the per-channel bias, multiplier and shift tables.
- INT32_SIZE, 32, datapath word width.
- PIPE_DEPTH, 4, requant pipeline latency in cycles. It is fixed; it is a localparam in the package.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd  input  7  command opcode, sampled every cycle.
- inp0  input  32  address, channel index or first operand.
- inp1  input  32  value, or the accumulator value for an issue command.
- ret  output  32  registered read data.
- word_ready  output  1  a packed output word is waiting to be read.

Behaviour:
- Commands take effect at the clock edge where they are sampled; unlisted cmd values are a no-op.
- 60 writes bias[inp0] = inp1.
- 61 writes mult[inp0] = inp1 (int32 multiplier).
- 62 writes shift[inp0] = inp1[5:0] (signed, range -31..+31; positive means left shift).
- 63 writes out_offset = inp1; 64 writes act_min = inp1; 65 writes act_max = inp1.
- 70 issues a requant: channel = inp0[6:0], acc = inp1. Back-to-back issue every cycle is allowed.
- 71 sets ret = out_word and clears word_ready.
- 72 sets ret = {overflow, 26'b0, pending_cnt[2:0], lane[1:0]}.
- 73 flushes: lane = 0, partial word = 0, overflow = 0. Results already in flight still land afterwards.
- Reset values:
  - ret = 0, word_ready = 0, overflow = 0, lane = 0, out_word = 0.
  - All pipeline valid bits = 0.
  - out_offset = 0, act_min = -128, act_max = 127.
  - Tables are not cleared (they are RAM).
- Reset mid-operation discards all in-flight results.
- Pipeline. Issue at edge N; the result is written into its lane at edge N+4.
  - S1: table read for the channel; x = acc + bias (wrapping 32-bit). If shift > 0, x = x << shift (wrapping).
  - S2: p = x * mult as a signed 64-bit product. Set sat if x == mult == INT32_MIN.
  - S3: nudge = (p >= 0) ? 2^30 : 1 - 2^30. h = (p + nudge) / 2^31, truncated toward zero. If sat, h = INT32_MAX.
  - S4, when shift < 0 with e = -shift:
    - mask = 2^e - 1; rem = h & mask; thr = (mask >> 1) + (h < 0).
    - r = (h >>> e) + (rem > thr).
    - Otherwise r = h.
    - Then y = r + out_offset, clamped to [act_min, act_max], and the low 8 bits are kept.
  - S4 uses the current out_offset and act_min/act_max. Software must not change them while pending_cnt != 0.
  - pending_cnt counts valid pipeline stages, 0..4.
- Packing (little-endian).
  - Each result is written to byte lane `lane` of the partial word, then lane increments.
  - On writing lane 3, out_word takes the completed word, word_ready = 1, lane = 0, and the partial word clears.
  - If a word completes while word_ready = 1, out_word is overwritten and overflow = 1 (sticky until cmd 73 or reset).
  - If cmd 71 coincides with a word completing, ret gets the old out_word and word_ready stays 1 with the new word.
  - If cmd 73 coincides with a result landing, the flush wins and the result is dropped.
- Channel index ≥ MAX_CHANNELS: only the low 7 bits are used (wrap); there is no error.

Decomposition:
- Package conv1d_pkg holds:
  - cmd opcode localparams (CMD_REQ_BIAS = 60 … CMD_REQ_FLUSH = 73);
  - PIPE_DEPTH and INT32_MIN/INT32_MAX;
  - a typedef for the pipeline stage struct (valid, x/p/h, shift, sat).
- One sub-module, requant_core: the pure 4-stage arithmetic pipeline, with in_valid/acc/bias/mult/shift in and out_valid/int8 out. Table storage, command decode and packing stay in the top level.

Test Plan:
- Basic path: ch0 bias = 20, mult = 0x40000000, shift = -1, offset = -5. Issue acc = 100 four times → word_ready rises 4 cycles after the 4th issue; cmd 71 returns 0x19191919 (25 per lane).
- Rounding: mult = 0x40000000. With shift = 0, acc = -3 gives lane value -1. With shift = -1, acc = -3 gives -1, and acc = -6 (h = -3 → -1.5) gives -2.
- Clamp and saturation:
  - mult = 0x7FFFFFFF, shift = 4, acc = 1000 → 127.
  - acc = -1000 → -128.
  - act_min = 0, acc = -1000 → 0.
  - bias = 0, mult = 0x80000000, acc = 0x80000000 → h = INT32_MAX → 127.
- Per-channel: 4 channels with distinct bias/mult/shift, issued back-to-back → all lanes correct. pending_cnt via cmd 72 reads 1, 2, 3, 4, then drains to 0.
- Overflow and simultaneity:
  - 8 issues with no read → overflow = 1 and out_word holds the second word.
  - cmd 71 on the completion edge → ret = old word, word_ready stays 1.
  - cmd 73 → status reads 0.
- Reset: issue 2 results, assert reset for 1 cycle → word_ready = 0, lane = 0, pending_cnt = 0, act_min/act_max back to -128/127. Tables are retained, and a subsequent 4 issues produce the correct word.
